led_pattern_seq: RTL and testbench

LED pattern sequencer for the board LED bank. A free-running prescaler produces a one-cycle tick every TICK_DIV clocks. On each tick the block advances the LED pattern selected by the MODE switches. It sits between the raw board clock and the 8 user LEDs, and is the consumer stage for slow divided-clock timing.

---
 rtl/led_pattern_seq_if.sv | 11 +
 rtl/led_pattern_seq.sv | 119 +++++++++++
 tb/tb_led_pattern_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_seq_if.sv
// Switch/LED bundle between the board I/O and the LED pattern sequencer.
// The sequencer takes the slave side; whoever drives the switches takes the master side.
interface led_pattern_seq_if;
   logic [1:0] MODE;
   logic       PAUSE;
   logic [7:0] LED;
   logic       TICK;

   modport master (output MODE, output PAUSE, input LED, input TICK);
   modport slave  (input MODE, input PAUSE, output LED, output TICK);
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: a free-running prescaler ticks every TICK_DIV clocks, and each
// tick advances the LED pattern chosen by the (synchronised) MODE switches.
module led_pattern_seq #(
   parameter int TICK_DIV = 25000000
) (
   input  logic            CLK,
   input  logic            RESET,
   led_pattern_seq_if.slave bus
);

   localparam int              CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_DIV - 1);

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          r_state;
   logic [1:0]      r_mode_s1;
   logic [1:0]      r_mode_s2;
   logic            r_pause_s1;
   logic            r_pause_s2;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_mode_cur;
   logic            r_dir;
   logic [7:0]      r_led;

   state_t          w_state_next;
   logic [CW-1:0]   w_cnt_next;
   logic [1:0]      w_mode_cur_next;
   logic            w_dir_next;
   logic [7:0]      w_led_next;
   logic            w_tick;
   logic [7:0]      w_shl;
   logic [7:0]      w_shr;

   assign w_tick   = (r_cnt == CNT_MAX);
   assign w_shl    = {r_led[6:0], 1'b0};
   assign w_shr    = {1'b0, r_led[7:1]};
   assign bus.TICK = w_tick;
   assign bus.LED  = r_led;

   function automatic logic [7:0] f_init(input logic [1:0] mode);
      f_init = (mode == 2'b01 || mode == 2'b10) ? 8'h01 : 8'h00;
   endfunction

   // Two-flop synchronisers for the switch and button inputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_mode_s1  <= 2'b00;
         r_mode_s2  <= 2'b00;
         r_pause_s1 <= 1'b0;
         r_pause_s2 <= 1'b0;
      end else begin
         r_mode_s1  <= bus.MODE;
         r_mode_s2  <= r_mode_s1;
         r_pause_s1 <= bus.PAUSE;
         r_pause_s2 <= r_pause_s1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state    <= ST_LOAD;
         r_cnt      <= '0;
         r_mode_cur <= 2'b00;
         r_dir      <= 1'b0;
         r_led      <= 8'h00;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_mode_cur <= w_mode_cur_next;
         r_dir      <= w_dir_next;
         r_led      <= w_led_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = w_tick ? '0 : r_cnt + CW'(1);
      w_mode_cur_next = r_mode_cur;
      w_dir_next      = r_dir;
      w_led_next      = r_led;

      case (r_state)
         ST_LOAD: begin
            w_mode_cur_next = r_mode_s2;
            w_led_next      = f_init(r_mode_s2);
            w_dir_next      = 1'b0;
            w_cnt_next      = '0;
            w_state_next    = ST_RUN;
         end
         ST_RUN: begin
            // A mode change wins over a coincident tick; the tick is simply dropped.
            if (r_mode_s2 != r_mode_cur) begin
               w_state_next = ST_LOAD;
            end else if (w_tick && !r_pause_s2) begin
               case (r_mode_cur)
                  2'b00: w_led_next = r_led + 8'd1;
                  2'b01: w_led_next = {r_led[6:0], r_led[7]};
                  2'b10: begin
                     if (!r_dir) begin
                        w_led_next = w_shl;
                        if (w_shl == 8'h80) w_dir_next = 1'b1;
                     end else begin
                        w_led_next = w_shr;
                        if (w_shr == 8'h01) w_dir_next = 1'b0;
                     end
                  end
                  default: w_led_next = ~r_led;
               endcase
            end
         end
         default: w_state_next = ST_LOAD;
      endcase
   end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq: a pattern-index reference model queues every
// expected LED change; a negedge monitor pops and compares each change the DUT shows.
module tb_led_pattern_seq;

   localparam int DIV = 4;

   logic CLK   = 1'b0;
   logic RESET = 1'b0;

   led_pattern_seq_if bus ();

   led_pattern_seq #(.TICK_DIV(DIV)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int         cyc;
      logic [7:0] led;
   } txn_t;

   txn_t sbq[$];

   // Reference model: the pattern is a pure function of (mode, steps since reload).
   logic [1:0] m_s1 = 2'b00, m_s2 = 2'b00, m_mode = 2'b00;
   logic       m_p1 = 1'b0, m_p2 = 1'b0;
   bit         m_reload = 1'b1;
   int         m_phase = 0;
   int         m_pos = 0;
   int         cycle = 0;
   logic [7:0] m_led = 8'h00;
   logic [7:0] m_new;
   logic [7:0] last_led = 8'h00;

   function automatic logic [7:0] pat(input logic [1:0] mode, input int pos);
      int k;
      logic [7:0] one;
      one = 8'h01;
      case (mode)
         2'b00: pat = 8'(pos % 256);
         2'b01: pat = one << (pos % 8);
         2'b10: begin
            k = pos % 14;
            pat = (k <= 7) ? (one << k) : (one << (14 - k));
         end
         default: pat = (pos % 2 == 1) ? 8'hFF : 8'h00;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = 2'b00; m_s2 = 2'b00; m_mode = 2'b00;
      m_p1 = 1'b0;  m_p2 = 1'b0;
      m_reload = 1'b1; m_phase = 0; m_pos = 0; m_led = 8'h00;
      sbq.delete();
   endtask

   task automatic model_step();
      cycle++;
      if (m_reload) begin
         m_mode = m_s2; m_pos = 0; m_phase = 0; m_reload = 1'b0;
      end else if (m_s2 != m_mode) begin
         m_reload = 1'b1;
         m_phase  = (m_phase + 1) % DIV;
      end else begin
         if (m_phase == DIV - 1 && !m_p2) m_pos++;
         m_phase = (m_phase + 1) % DIV;
      end
      m_s2 = m_s1; m_s1 = bus.MODE;
      m_p2 = m_p1; m_p1 = bus.PAUSE;
      m_new = pat(m_mode, m_pos);
      if (m_new != m_led) sbq.push_back('{cyc: cycle, led: m_new});
      m_led = m_new;
   endtask

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) model_reset();
      else        model_step();
   end

   // Monitor: every LED change is one transaction.
   always @(negedge CLK) begin
      txn_t t;
      if (!RESET) begin
         last_led = 8'h00;
      end else begin
         chk("tick", 32'(bus.TICK), (m_phase == DIV - 1) ? 32'd1 : 32'd0);
         if (bus.LED !== last_led) begin
            if (sbq.size() == 0) begin
               chk("unexpected_change", 32'(bus.LED), 32'(last_led));
            end else begin
               t = sbq.pop_front();
               $display("txn cycle=%0d led=%02h exp_led=%02h exp_cycle=%0d",
                        cycle, bus.LED, t.led, t.cyc);
               chk("led_value", 32'(bus.LED), 32'(t.led));
               chk("led_cycle", cycle, t.cyc);
            end
            last_led = bus.LED;
         end
      end
   end

   task automatic wait_led(input logic [7:0] v, input int budget, input string nm);
      int k = 0;
      while (bus.LED !== v && k < budget) begin
         @(negedge CLK);
         k++;
      end
      chk(nm, 32'(bus.LED), 32'(v));
   endtask

   task automatic wait_change(input logic [7:0] v, input int budget, input string nm);
      logic [7:0] l0;
      int k = 0;
      l0 = bus.LED;
      while (bus.LED === l0 && k < budget) begin
         @(negedge CLK);
         k++;
      end
      chk(nm, 32'(bus.LED), 32'(v));
   endtask

   // Asynchronous reset applied between edges; outputs must clear before any clock edge.
   task automatic apply_reset(input logic [1:0] mode);
      @(negedge CLK);
      #2 RESET = 1'b0;
      bus.MODE = mode;
      #1;
      chk("rst_led_async", 32'(bus.LED), 32'h00);
      chk("rst_tick_async", 32'(bus.TICK), 32'h0);
      repeat (3) @(negedge CLK);
      chk("rst_led_hold", 32'(bus.LED), 32'h00);
      #2 RESET = 1'b1;
   endtask

   initial begin
      logic [7:0] lv;
      logic [7:0] frozen;
      int ticks;
      int k;

      bus.MODE  = 2'b00;
      bus.PAUSE = 1'b0;

      // Count mode from reset, through the FF->00 wrap.
      apply_reset(2'b00);
      wait_led(8'h01, 8, "count_first");
      wait_led(8'hFF, 1100, "count_ff");
      wait_change(8'h00, 8, "count_wrap");

      // Pause at 05: LED freezes, prescaler keeps ticking.
      wait_led(8'h05, 40, "pause_reach5");
      bus.PAUSE = 1'b1;
      repeat (8) @(negedge CLK);
      frozen = bus.LED;
      chk("pause_frozen", 32'(frozen), 32'h05);
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (bus.TICK) ticks++;
      end
      chk("pause_ticks", ticks, 5);
      chk("pause_hold", 32'(bus.LED), 32'(frozen));
      bus.PAUSE = 1'b0;
      wait_change(8'h06, 12, "pause_resume");

      // Mode change 00->01 landing on a tick: no advance, reload on the 4th edge.
      k = 0;
      while (m_phase != DIV - 3 && k < 10) begin
         @(negedge CLK);
         k++;
      end
      chk("mchg_phase_found", (m_phase == DIV - 3) ? 1 : 0, 1);
      lv = bus.LED;
      bus.MODE = 2'b01;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("mchg_no_advance", 32'(bus.LED), 32'(lv));
      @(negedge CLK);
      chk("mchg_reload", 32'(bus.LED), 32'h01);
      chk("mchg_cnt_restart", 32'(bus.TICK), 32'h0);

      // Rotate mode selected while in reset: reload on the 4th edge after release.
      apply_reset(2'b01);
      repeat (3) @(negedge CLK);
      chk("rot_pre_load", 32'(bus.LED), 32'h00);
      @(negedge CLK);
      chk("rot_load", 32'(bus.LED), 32'h01);
      wait_led(8'h80, 40, "rot_80");
      wait_change(8'h01, 8, "rot_wrap");

      // Ping-pong: endpoints are not repeated.
      bus.MODE = 2'b10;
      wait_led(8'h80, 60, "pp_80");
      wait_change(8'h40, 8, "pp_turn_high");
      wait_led(8'h01, 40, "pp_01");
      wait_change(8'h02, 8, "pp_turn_low");

      // Blink.
      bus.MODE = 2'b11;
      wait_led(8'h00, 12, "blink_init");
      wait_change(8'hFF, 8, "blink_ff");
      wait_change(8'h00, 8, "blink_00");

      // Randomised mode switching and pausing.
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if ($urandom_range(0, 149) == 0) bus.MODE = 2'($urandom);
         if ($urandom_range(0, 39) == 0)  bus.PAUSE = ~bus.PAUSE;
      end
      bus.PAUSE = 1'b0;

      // Reset mid-operation with a partially counted prescaler.
      bus.MODE = 2'b00;
      wait_led(8'h00, 20, "pre_mid_reset_load");
      wait_led(8'h03, 30, "pre_mid_reset_cnt");
      @(negedge CLK);
      apply_reset(2'b00);
      wait_led(8'h01, 8, "post_reset_first");

      repeat (10) @(negedge CLK);
      chk("sb_empty", sbq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
